// File: rtl/imm_gen_stage.sv
// Registered RV immediate generator with a two-entry (main + skid) output buffer.
// Optional CSR zimm decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_stage #(
   parameter int XLEN        = 64,
   parameter int TAG_W       = 8,
   parameter int BR_BYTE_OFS = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      inst_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       imm_type_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_I    = 3'd1;
   localparam logic [2:0] T_S    = 3'd2;
   localparam logic [2:0] T_B    = 3'd3;
   localparam logic [2:0] T_U    = 3'd4;
   localparam logic [2:0] T_J    = 3'd5;
   localparam logic [2:0] T_Z    = 3'd6;

   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

   state_e             state_q;
   logic               in_ready_q;
   logic               m_valid_q, k_valid_q;
   logic [XLEN-1:0]    m_imm_q, k_imm_q;
   logic [2:0]         m_type_q, k_type_q;
   logic [TAG_W-1:0]   m_tag_q, k_tag_q;

   logic [31:0]        imm32;
   logic [XLEN-1:0]    imm_d;
   logic [2:0]         type_d;
   logic               in_fire, out_fire;

   // Every format fits in 32 bits even after the optional branch shift,
   // so build it sign-extended to 32 and widen once.
   always_comb begin
      imm32  = '0;
      type_d = T_NONE;
      case (inst_i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
            type_d = T_I;
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               imm32  = {{20{inst_i[31]}}, inst_i[31:20]};
               type_d = T_I;
            end
         end
         7'b0100011: begin
            imm32  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            type_d = T_S;
         end
         7'b1100011: begin
            if (BR_BYTE_OFS != 0)
               imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            else
               imm32 = {{20{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8]};
            type_d = T_B;
         end
         7'b0110111, 7'b0010111: begin
            imm32  = {inst_i[31:12], 12'b0};
            type_d = T_U;
         end
         7'b1101111: begin
            if (BR_BYTE_OFS != 0)
               imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            else
               imm32 = {{12{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21]};
            type_d = T_J;
         end
`ifdef IMM_GEN_ZICSR_EN
         7'b1110011: begin
            if (inst_i[14]) begin
               imm32  = {27'b0, inst_i[19:15]};
               type_d = T_Z;
            end
         end
`endif
         default: begin
            imm32  = '0;
            type_d = T_NONE;
         end
      endcase
      imm_d = XLEN'($signed(imm32));
   end

   assign in_fire  = in_valid_i & in_ready_q;
   assign out_fire = m_valid_q & out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         m_valid_q  <= 1'b0;
         k_valid_q  <= 1'b0;
         m_imm_q    <= '0;
         m_type_q   <= '0;
         m_tag_q    <= '0;
         k_imm_q    <= '0;
         k_type_q   <= '0;
         k_tag_q    <= '0;
      end else if (flush_i) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         m_valid_q  <= 1'b0;
         k_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  m_imm_q   <= imm_d;
                  m_type_q  <= type_d;
                  m_tag_q   <= tag_i;
                  m_valid_q <= 1'b1;
                  state_q   <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  m_imm_q  <= imm_d;
                  m_type_q <= type_d;
                  m_tag_q  <= tag_i;
               end else if (in_fire) begin
                  k_imm_q    <= imm_d;
                  k_type_q   <= type_d;
                  k_tag_q    <= tag_i;
                  k_valid_q  <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SKID;
               end else if (out_fire) begin
                  m_valid_q <= 1'b0;
                  state_q   <= ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  m_imm_q    <= k_imm_q;
                  m_type_q   <= k_type_q;
                  m_tag_q    <= k_tag_q;
                  k_valid_q  <= 1'b0;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_FULL;
               end
            end
            default: begin
               state_q    <= ST_EMPTY;
               in_ready_q <= 1'b1;
               m_valid_q  <= 1'b0;
               k_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = m_valid_q;
   assign imm_o       = m_imm_q;
   assign imm_type_o  = m_type_q;
   assign tag_o       = m_tag_q;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate generator for the decode stage. Each cycle it accepts one 32-bit RV instruction with an opaque tag and extracts the sign-extended immediate at XLEN width. It classifies the immediate format and presents the result one cycle later through a valid/ready output backed by a two-entry skid buffer. It sits between instruction fetch/decode and the execute-stage operand muxes, and adds branch-offset scaling, W-form opcodes and flush handling.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- TAG_W, 8: width of the pass-through tag (PC index, ROB id, etc.).
- BR_BYTE_OFS, 0: 0 = B/J immediates are halfword offsets (bit 0 dropped); 1 = byte offsets (imm << 1).
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous pipeline flush; drops all buffered entries.
- in_valid_i  in  1  input instruction valid.
- in_ready_o  out  1  stage can accept an input this cycle.
- inst_i  in  32  instruction word.
- tag_i  in  TAG_W  tag travelling with the instruction.
- out_valid_o  out  1  imm_o/imm_type_o/tag_o valid.
- out_ready_i  in  1  downstream accepts output.
- imm_o  out  XLEN  sign-extended immediate.
- imm_type_o  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- tag_o  out  TAG_W  tag of the presented entry.

## Operation
- Classification is by opcode inst_i[6:0]:
  - I: 0010011, 0000011, 1100111; also 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: NONE, imm 0.
- Immediate formation:
  - I = sext(inst[31:20]).
  - S = sext({inst[31:25],inst[11:7]}).
  - B = sext({inst[31],inst[7],inst[30:25],inst[11:8]}).
  - J = sext({inst[31],inst[19:12],inst[20],inst[30:21]}).
  - U = sext({inst[31:12],12'b0}).
  - All sign extension is from the format's MSB to XLEN.
  - B/J get an extra LSB zero when BR_BYTE_OFS=1, sign-extended after the shift.
- Buffering is a main register M feeding the outputs plus a skid register K. State machine:
  - EMPTY (M and K invalid). Input handshake → FULL.
  - FULL (M valid). Output handshake with no input → EMPTY. Input with no output handshake → SKID (entry written to K). Both handshakes → stay FULL, M replaced.
  - SKID (M and K valid). Output handshake → FULL, K moves to M. No input is accepted in SKID.
- in_ready_o is registered and equals "K empty". It never depends combinationally on out_ready_i.
- Ordering is strictly FIFO; no entry is dropped except by flush or reset.
- flush_i forces EMPTY next cycle regardless of state:
  - An input presented in the flush cycle is discarded.
  - An output handshake in the flush cycle still counts as consumed by downstream.
- Output payload is held stable while out_valid_o=1 and out_ready_i=0.

## Timing
- Latency: input handshake at edge N → out_valid_o high after edge N, with its payload.
- Throughput: 1 instruction/cycle while out_ready_i=1.
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid_o=0, imm_o=0, imm_type_o=0, tag_o=0.
  - in_ready_o=1; state EMPTY.
- Reset mid-operation loses all entries immediately, without waiting for a clock.
- in_valid_i with in_ready_o=0 has no effect; the source must hold the input.
- Simultaneous flush_i and rst_i: reset dominates.

## Configuration
- IMM_GEN_ZICSR_EN defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → type Z, imm_o = zero-extended inst[19:15].
- Not defined: every 1110011 instruction → type NONE, imm_o=0.
- No other behaviour changes.

## Test plan
- XLEN=64, inst 0xFFF00093 (addi -1) → next cycle imm_o=0xFFFF_FFFF_FFFF_FFFF, type 1. inst 0xFE20AE23 (sw -4) → imm_o=-4, type 2.
- inst 0xFE000CE3 (beq, offset -8) → imm_o=-4 when BR_BYTE_OFS=0 and imm_o=-8 when BR_BYTE_OFS=1, type 3 in both cases.
- U-format and W-form opcodes:
  - inst 0x123452B7 → imm_o=0x0000_0000_1234_5000, type 4.
  - inst 0x80000037 → 0xFFFF_FFFF_8000_0000 for XLEN=64, 0x8000_0000 for XLEN=32.
  - opcode 0011011 → type 1 for XLEN=64, type 0 for XLEN=32.
- Backpressure:
  - Hold out_ready_i=0 and stream tags 1,2,3 → tags 1 and 2 accepted, in_ready_o falls the cycle after tag 2.
  - Release out_ready_i → outputs 1,2,3 in order, no gaps beyond the single refill cycle.
- Assert flush_i in SKID with in_valid_i=1 → out_valid_o=0 and in_ready_o=1 next cycle, the new input is not emitted. Assert rst_i mid-stream → outputs zero asynchronously.
- inst 0x3002D0F3 (csrrwi imm 5) → imm_o=5, type 6 with IMM_GEN_ZICSR_EN; imm_o=0, type 0 without.
